// File: rtl/arena_arb_pkg.sv
// Shared types and default widths for the ArenaRAM port arbiter.
package arena_arb_pkg;

  localparam int ARENA_ADDR_W = 10;
  localparam int ARENA_DATA_W = 32;
  localparam int ARENA_LEN_W  = 6;

  // Burst fetcher phases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arbState;

  // Who owned the RAM port on the cycle just issued.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } arbOwner;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the video fetcher lost the port.
// forceGrant rises once the count reaches MAX_WAIT.
module arb_starve_counter
  import arena_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic forceGrant
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] waitCnt;

  // Clear wins over increment; the count holds once saturated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (clr) begin
      waitCnt <= '0;
    end else if (inc && (waitCnt != CNT_MAX)) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  assign forceGrant = (waitCnt == CNT_MAX);

endmodule

// File: rtl/arena_port_arbiter.sv
// Shares the single synchronous-read ArenaRAM port between the CPU data path
// and the video burst fetcher. CPU has priority; the starvation counter forces
// one video grant after MAX_WAIT consecutive losses.
//
// CPU handshake: cpu_req acts as valid and ~cpu_stall as ready. A request is
// accepted in a cycle where cpu_req=1 and cpu_stall=0; while cpu_stall=1 the
// CPU must hold cpu_req/cpu_we/cpu_addr/cpu_wdata stable. An accepted read
// returns cpu_rdata with cpu_rvalid exactly one cycle later.
module arena_port_arbiter
  import arena_arb_pkg::*;
#(
  parameter int ADDR_W   = ARENA_ADDR_W,
  parameter int DATA_W   = ARENA_DATA_W,
  parameter int LEN_W    = ARENA_LEN_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vid_start,
  input  logic [ADDR_W-1:0] vid_base,
  input  logic [LEN_W-1:0]  vid_len,
  output logic              vid_busy,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  output logic [LEN_W-1:0]  vid_idx,
  output logic              vid_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output arbState           dbgState
);

  arbState           state, stateNext;
  logic [ADDR_W-1:0] burstBase;
  logic [LEN_W-1:0]  burstLen;
  logic [LEN_W-1:0]  issued;
  logic [ADDR_W-1:0] burstAddr;
  logic              vidGrant, cpuGrant, forceGrant;
  logic              startAccept, lastIssue;
  logic              vidDone;
  arbOwner           tagOwner;
  logic              tagWrite;
  logic [LEN_W-1:0]  tagIdx;

  assign vid_busy    = (state != ST_IDLE) | vidDone;
  assign startAccept = vid_start & (vid_len != '0) & ~vid_busy;
  assign lastIssue   = vidGrant & (issued == (burstLen - 1'b1));
  assign burstAddr   = burstBase + ADDR_W'(issued);

  // Port grant and RAM mux; reset forces every combinational output low.
  always_comb begin
    vidGrant  = 1'b0;
    cpuGrant  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!reset) begin
      vidGrant = (state == ST_BURST) & (~cpu_req | forceGrant);
      cpuGrant = cpu_req & ~vidGrant;
    end
    if (vidGrant) begin
      ram_addr = burstAddr;
    end else if (cpuGrant) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  // Next-state logic for the burst fetcher.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (startAccept) stateNext = ST_BURST;
      ST_BURST: if (lastIssue) stateNext = ST_DRAIN;
      ST_DRAIN: stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // Burst parameters are captured on an accepted start; issued counts grants.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      burstBase <= '0;
      burstLen  <= '0;
      issued    <= '0;
    end else if (startAccept) begin
      burstBase <= vid_base;
      burstLen  <= vid_len;
      issued    <= '0;
    end else if (vidGrant) begin
      issued <= issued + 1'b1;
    end
  end

  // vid_done pulses on the cycle after DRAIN, once the last read is back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vidDone <= 1'b0;
    else       vidDone <= (state == ST_DRAIN);
  end

  // One-deep return tag for the access issued this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tagOwner <= OWN_NONE;
      tagWrite <= 1'b0;
      tagIdx   <= '0;
    end else begin
      tagOwner <= vidGrant ? OWN_VID : (cpuGrant ? OWN_CPU : OWN_NONE);
      tagWrite <= cpuGrant & cpu_we;
      tagIdx   <= vidGrant ? issued : '0;
    end
  end

  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) uStarve (
    .clock      (clock),
    .reset      (reset),
    .inc        ((state == ST_BURST) & cpu_req & ~vidGrant),
    .clr        (vidGrant | (state != ST_BURST)),
    .forceGrant (forceGrant)
  );

  assign cpu_stall  = cpu_req & ~cpuGrant & ~reset;
  assign cpu_rvalid = (tagOwner == OWN_CPU) & ~tagWrite;
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
  assign vid_valid  = (tagOwner == OWN_VID);
  assign vid_rdata  = vid_valid ? ram_rdata : '0;
  assign vid_idx    = vid_valid ? tagIdx : '0;
  assign vid_done   = vidDone;
  assign dbgState   = state;

endmodule

// File: tb/tb_arena_port_arbiter.sv
// Bench for arena_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model with a video return queue.
module tb_arena_port_arbiter;
  import arena_arb_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 6;
  localparam int MAX_WAIT = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vid_start = 1'b0;
  logic [ADDR_W-1:0] vid_base = '0;
  logic [LEN_W-1:0]  vid_len = '0;
  logic              vid_busy, vid_valid, vid_done;
  logic [DATA_W-1:0] vid_rdata;
  logic [LEN_W-1:0]  vid_idx;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  arbState           dbgState;

  int nChecks = 0;
  int nFail   = 0;

  // clock / reset
  always #5 clock = ~clock;

  arena_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vid_start(vid_start), .vid_base(vid_base), .vid_len(vid_len),
    .vid_busy(vid_busy), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .vid_idx(vid_idx), .vid_done(vid_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dbgState(dbgState)
  );

  function automatic logic [DATA_W-1:0] pattern(input int i);
    return 32'hC0DE_0000 | DATA_W'(i);
  endfunction

  // ArenaRAM stand-in: synchronous read, old data on read.
  logic              ramLoad = 1'b1;
  logic [DATA_W-1:0] ram [1024];
  always @(posedge clock) begin
    if (ramLoad) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pattern(i);
      ram_rdata <= '0;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_start = 1'b0; vid_base = '0; vid_len = '0;
  endtask

  task automatic settle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // reference model (transaction level) and scoreboard
  logic [DATA_W-1:0]       refMem [1024];
  logic [LEN_W+DATA_W-1:0] exp_q[$];
  int                      mLeft, mIssued, mWait;
  logic [ADDR_W-1:0]       mBase;
  bit                      mDrain, mDone, mCpuRd;
  logic [DATA_W-1:0]       mCpuData;
  bit                      eVidWin, eCpuWin, eWe, eStall, eBusy;
  logic [ADDR_W-1:0]       eAddr;

  task automatic model_clear();
    mLeft = 0; mIssued = 0; mWait = 0; mBase = '0;
    mDrain = 0; mDone = 0; mCpuRd = 0; mCpuData = '0;
    eStall = 0;
    exp_q.delete();
  endtask

  task automatic model_eval();
    eVidWin = (mLeft > 0) && (!cpu_req || mWait == MAX_WAIT);
    eCpuWin = cpu_req && !eVidWin;
    eAddr   = eVidWin ? ADDR_W'(int'(mBase) + mIssued) : (eCpuWin ? cpu_addr : '0);
    eWe     = eCpuWin && cpu_we;
    eStall  = cpu_req && !eCpuWin;
    eBusy   = (mLeft > 0) || mDrain || mDone;
  endtask

  task automatic model_commit();
    if (eVidWin) exp_q.push_back({LEN_W'(mIssued), refMem[eAddr]});
    mCpuRd   = eCpuWin && !cpu_we;
    mCpuData = refMem[cpu_addr];
    if (eCpuWin && cpu_we) refMem[cpu_addr] = cpu_wdata;
    mDone  = mDrain;
    mDrain = 0;
    if (eVidWin) begin
      mIssued++; mLeft--; mWait = 0;
      if (mLeft == 0) mDrain = 1;
    end else if (mLeft > 0 && cpu_req) begin
      mWait = (mWait < MAX_WAIT) ? mWait + 1 : MAX_WAIT;
    end else begin
      mWait = 0;
    end
    if (vid_start && !eBusy && vid_len != '0) begin
      mLeft = int'(vid_len); mIssued = 0; mBase = vid_base; mWait = 0;
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [117:0] outs;
    reset = 1'b1; ramLoad = 1'b1; idle_inputs();
    next_cycle();
    ramLoad = 1'b0;
    @(negedge clock);
    outs = {cpu_stall, cpu_rdata, cpu_rvalid, vid_busy, vid_rdata, vid_valid,
            vid_idx, vid_done, ram_we, ram_addr, ram_wdata};
    nChecks++;
    if (outs !== '0) begin nFail++; $display("FAIL reset_outs got=%h exp=0", outs); end
    nChecks++;
    if (dbgState !== ST_IDLE) begin nFail++; $display("FAIL reset_state got=%0d exp=%0d", dbgState, ST_IDLE); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h005; cpu_wdata = 32'h1234_5678;
    #1;
    nChecks++;
    if ({cpu_stall, ram_we, ram_addr} !== 12'h000) begin
      nFail++; $display("FAIL reset_cpu_blocked got=%h exp=000", {cpu_stall, ram_we, ram_addr});
    end
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    settle(2);
  endtask

  task automatic test_idle_burst();
    logic [ADDR_W-1:0] ea;
    logic [13:0]       ectl;
    for (int k = 0; k < 8; k++) begin
      vid_start = (k == 0); vid_base = 10'h010; vid_len = 6'd4;
      @(negedge clock);
      ea   = (k >= 1 && k <= 4) ? ADDR_W'(16 + k - 1) : '0;
      ectl = {ea, (k >= 2 && k <= 5), (k == 6), (k >= 1 && k <= 6), 1'b0};
      nChecks++;
      if ({ram_addr, vid_valid, vid_done, vid_busy, cpu_stall} !== ectl) begin
        nFail++; $display("FAIL idle_ctl k=%0d got=%h exp=%h", k,
                          {ram_addr, vid_valid, vid_done, vid_busy, cpu_stall}, ectl);
      end
      if (k >= 2 && k <= 5) begin
        nChecks++;
        if ({vid_idx, vid_rdata} !== {LEN_W'(k - 2), pattern(16 + k - 2)}) begin
          nFail++; $display("FAIL idle_data k=%0d got=%h/%h exp=%0d/%h", k, vid_idx, vid_rdata,
                            k - 2, pattern(16 + k - 2));
        end
      end
      next_cycle();
    end
    settle(2);
  endtask

  task automatic test_starvation();
    logic [ADDR_W-1:0] ea;
    logic              vidK, erv;
    for (int k = 0; k <= 12; k++) begin
      vid_start = (k == 0); vid_base = 10'h040; vid_len = 6'd2;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ADDR_W'(256 + k);
      @(negedge clock);
      vidK = (k == 5 || k == 10);
      ea   = vidK ? ADDR_W'(64 + (k == 10 ? 1 : 0)) : ADDR_W'(256 + k);
      erv  = (k >= 1) && !((k - 1) == 5 || (k - 1) == 10);
      nChecks++;
      if ({cpu_stall, ram_addr, cpu_rvalid, vid_valid, vid_done} !==
          {vidK, ea, erv, (k == 6 || k == 11), (k == 12)}) begin
        nFail++; $display("FAIL starve_ctl k=%0d got=%h exp=%h", k,
                          {cpu_stall, ram_addr, cpu_rvalid, vid_valid, vid_done},
                          {vidK, ea, erv, (k == 6 || k == 11), (k == 12)});
      end
      if (erv) begin
        nChecks++;
        if (cpu_rdata !== pattern(256 + k - 1)) begin
          nFail++; $display("FAIL starve_cpu_rdata k=%0d got=%h exp=%h", k, cpu_rdata, pattern(256 + k - 1));
        end
      end
      next_cycle();
    end
    settle(2);
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] wrapSeq [4];
    wrapSeq = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    for (int k = 0; k < 6; k++) begin
      vid_start = (k == 0); vid_base = 10'h3FE; vid_len = 6'd4;
      @(negedge clock);
      if (k >= 1 && k <= 4) begin
        nChecks++;
        if (ram_addr !== wrapSeq[k-1]) begin
          nFail++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, ram_addr, wrapSeq[k-1]);
        end
      end
      if (k >= 2) begin
        nChecks++;
        if ({vid_valid, vid_idx, vid_rdata} !== {1'b1, LEN_W'(k - 2), pattern(int'(wrapSeq[k-2]))}) begin
          nFail++; $display("FAIL wrap_data k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, vid_valid, vid_idx,
                            vid_rdata, k - 2, pattern(int'(wrapSeq[k-2])));
        end
      end
      next_cycle();
    end
    settle(2);
  endtask

  task automatic test_hazard();
    for (int k = 0; k <= 8; k++) begin
      vid_start = (k == 0); vid_base = 10'h020; vid_len = 6'd1;
      if (k <= 4)       begin cpu_req = 1; cpu_we = 0; cpu_addr = 10'h200; cpu_wdata = '0; end
      else if (k <= 6)  begin cpu_req = 1; cpu_we = 1; cpu_addr = 10'h020; cpu_wdata = 32'hDEADBEEF; end
      else if (k == 7)  begin cpu_req = 1; cpu_we = 0; cpu_addr = 10'h020; cpu_wdata = '0; end
      else              begin cpu_req = 0; cpu_we = 0; end
      @(negedge clock);
      if (k == 5) begin
        nChecks++;
        if ({cpu_stall, ram_we, ram_addr} !== {1'b1, 1'b0, 10'h020}) begin
          nFail++; $display("FAIL hazard_forced got=%h exp=%h", {cpu_stall, ram_we, ram_addr}, {2'b10, 10'h020});
        end
      end
      if (k == 6) begin
        nChecks++;
        if ({cpu_stall, ram_we, ram_addr, ram_wdata} !== {1'b0, 1'b1, 10'h020, 32'hDEADBEEF}) begin
          nFail++; $display("FAIL hazard_write got=%h exp=%h", {cpu_stall, ram_we, ram_addr, ram_wdata},
                            {2'b01, 10'h020, 32'hDEADBEEF});
        end
        nChecks++;
        if ({vid_valid, vid_rdata} !== {1'b1, pattern(32)}) begin
          nFail++; $display("FAIL hazard_old_data got=%b/%h exp=1/%h", vid_valid, vid_rdata, pattern(32));
        end
      end
      if (k == 7) begin
        nChecks++;
        if ({vid_done, cpu_stall} !== 2'b10) begin
          nFail++; $display("FAIL hazard_done got=%b exp=10", {vid_done, cpu_stall});
        end
      end
      if (k == 8) begin
        nChecks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hDEADBEEF}) begin
          nFail++; $display("FAIL hazard_readback got=%b/%h exp=1/deadbeef", cpu_rvalid, cpu_rdata);
        end
      end
      next_cycle();
    end
    settle(2);
  endtask

  task automatic test_ignored_starts();
    logic [ADDR_W-1:0] ea;
    vid_start = 1'b1; vid_base = 10'h123; vid_len = 6'd0;
    next_cycle();
    vid_start = 1'b0;
    @(negedge clock);
    nChecks++;
    if ({vid_busy, dbgState, ram_addr} !== {1'b0, ST_IDLE, 10'h000}) begin
      nFail++; $display("FAIL zero_len got=%b/%0d/%h exp=0/0/000", vid_busy, dbgState, ram_addr);
    end
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      vid_start = (k == 0 || k == 2 || k == 4);
      vid_base  = (k == 0) ? 10'h080 : (k == 2 ? 10'h300 : 10'h200);
      vid_len   = (k == 0) ? 6'd3 : (k == 2 ? 6'd7 : 6'd5);
      @(negedge clock);
      ea = (k >= 1 && k <= 3) ? ADDR_W'(128 + k - 1) : '0;
      nChecks++;
      if ({ram_addr, vid_busy, vid_done, vid_valid} !==
          {ea, (k >= 1 && k <= 5), (k == 5), (k >= 2 && k <= 4)}) begin
        nFail++; $display("FAIL ignored_ctl k=%0d got=%h exp=%h", k, {ram_addr, vid_busy, vid_done, vid_valid},
                          {ea, (k >= 1 && k <= 5), (k == 5), (k >= 2 && k <= 4)});
      end
      if (k == 4) begin
        nChecks++;
        if (dbgState !== ST_DRAIN) begin
          nFail++; $display("FAIL ignored_drain_state got=%0d exp=%0d", dbgState, ST_DRAIN);
        end
      end
      next_cycle();
    end
    settle(2);
  endtask

  task automatic test_reset_mid_burst();
    logic [117:0] outs;
    for (int k = 0; k < 3; k++) begin
      vid_start = (k == 0); vid_base = 10'h0C0; vid_len = 6'd8;
      next_cycle();
    end
    vid_start = 1'b0;
    nChecks++;
    if ({vid_valid, vid_idx} !== {1'b1, 6'd1}) begin
      nFail++; $display("FAIL rst_pre got=%b/%0d exp=1/1", vid_valid, vid_idx);
    end
    reset = 1'b1;
    #1;
    outs = {cpu_stall, cpu_rdata, cpu_rvalid, vid_busy, vid_rdata, vid_valid,
            vid_idx, vid_done, ram_we, ram_addr, ram_wdata};
    nChecks++;
    if (outs !== '0) begin nFail++; $display("FAIL rst_async_outs got=%h exp=0", outs); end
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      nChecks++;
      if ({vid_done, vid_busy, vid_valid} !== 3'b000) begin
        nFail++; $display("FAIL rst_no_done k=%0d got=%b exp=000", k, {vid_done, vid_busy, vid_valid});
      end
      next_cycle();
    end
    for (int k = 0; k < 5; k++) begin
      vid_start = (k == 0); vid_base = 10'h0D0; vid_len = 6'd2;
      @(negedge clock);
      if (k == 1 || k == 2) begin
        nChecks++;
        if (ram_addr !== ADDR_W'(208 + k - 1)) begin
          nFail++; $display("FAIL rst_new_addr k=%0d got=%h exp=%h", k, ram_addr, ADDR_W'(208 + k - 1));
        end
      end
      if (k == 2 || k == 3) begin
        nChecks++;
        if ({vid_valid, vid_idx, vid_rdata} !== {1'b1, LEN_W'(k - 2), pattern(208 + k - 2)}) begin
          nFail++; $display("FAIL rst_new_data k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, vid_valid, vid_idx,
                            vid_rdata, k - 2, pattern(208 + k - 2));
        end
      end
      if (k == 4) begin
        nChecks++;
        if (vid_done !== 1'b1) begin nFail++; $display("FAIL rst_new_done got=%b exp=1", vid_done); end
      end
      next_cycle();
    end
    settle(2);
  endtask

  task automatic test_random();
    logic [LEN_W+DATA_W-1:0] exp;
    logic [14:0]             ectl;
    reset = 1'b1; idle_inputs();
    next_cycle();
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 1024; i++) refMem[i] = ram[i];
    for (int i = 0; i < 420; i++) begin
      if (i >= 400) begin
        idle_inputs();
      end else begin
        if (!eStall) begin
          cpu_req   = ($urandom_range(0, 3) != 0);
          cpu_we    = ($urandom_range(0, 2) == 0);
          cpu_addr  = ADDR_W'($urandom_range(0, 1023));
          cpu_wdata = $urandom;
        end
        vid_start = ($urandom_range(0, 7) == 0);
        vid_base  = ADDR_W'($urandom_range(0, 1023));
        vid_len   = LEN_W'($urandom_range(0, 12));
      end
      @(negedge clock);
      model_eval();
      ectl = {eAddr, eWe, eStall, eBusy, mDone, mCpuRd};
      nChecks++;
      if ({ram_addr, ram_we, cpu_stall, vid_busy, vid_done, cpu_rvalid} !== ectl) begin
        nFail++; $display("FAIL rand_ctl i=%0d got=%h exp=%h", i,
                          {ram_addr, ram_we, cpu_stall, vid_busy, vid_done, cpu_rvalid}, ectl);
      end
      if (eWe) begin
        nChecks++;
        if (ram_wdata !== cpu_wdata) begin
          nFail++; $display("FAIL rand_wdata i=%0d got=%h exp=%h", i, ram_wdata, cpu_wdata);
        end
      end
      if (mCpuRd) begin
        nChecks++;
        if (cpu_rdata !== mCpuData) begin
          nFail++; $display("FAIL rand_cpu_rdata i=%0d got=%h exp=%h", i, cpu_rdata, mCpuData);
        end
      end
      nChecks++;
      if (vid_valid !== (exp_q.size() != 0)) begin
        nFail++; $display("FAIL rand_vid_valid i=%0d got=%b exp=%b", i, vid_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        nChecks++;
        if ({vid_idx, vid_rdata} !== exp) begin
          nFail++; $display("FAIL rand_vid_word i=%0d got=%h exp=%h", i, {vid_idx, vid_rdata}, exp);
        end
      end
      model_commit();
      next_cycle();
    end
    nChecks++;
    if (exp_q.size() != 0) begin nFail++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    settle(2);
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_idle_burst();
    test_starvation();
    test_wrap();
    test_hazard();
    test_ignored_starts();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arena_port_arbiter.md
# arena_port_arbiter

Shares the single synchronous-read port of ArenaRAM between the CPU data-memory path and a video-side burst fetcher. The CPU has priority. The fetcher streams contiguous tile words into the VGA controller's line buffer. A starvation counter guarantees forward progress for video, and a stall output holds the CPU off during forced video cycles. The block sits between the Wrapper's arena decode (`arenaRamAccess`, `memAddr[11:2]`) and the ArenaRAM instance.

## Interface
- `ADDR_W`, default 10: ArenaRAM word address width (1024 entries).
- `DATA_W`, default 32: word width.
- `LEN_W`, default 6: burst length width (1..63 words).
- `MAX_WAIT`, default 4: consecutive lost cycles after which video is forced one grant.

Ports:
- `clock` in 1: system clock (25 MHz domain).
- `reset` in 1: asynchronous, active-high; clears all state.
- `cpu_req` in 1: CPU arena access this cycle (`arenaRamAccess`).
- `cpu_we` in 1: CPU write.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_stall` out 1: CPU request not granted this cycle; CPU must hold its request.
- `cpu_rdata` out DATA_W: CPU read data.
- `cpu_rvalid` out 1: `cpu_rdata` valid.
- `vid_start` in 1: one-cycle burst request.
- `vid_base` in ADDR_W: burst start address.
- `vid_len` in LEN_W: burst word count.
- `vid_busy` out 1: burst in progress.
- `vid_rdata` out DATA_W: fetched word.
- `vid_valid` out 1: `vid_rdata` valid.
- `vid_idx` out LEN_W: index of the fetched word within the burst (0-based).
- `vid_done` out 1: one-cycle pulse after the last word returns.
- `ram_we` out 1: ArenaRAM write enable.
- `ram_addr` out ADDR_W: ArenaRAM address.
- `ram_wdata` out DATA_W: ArenaRAM write data.
- `ram_rdata` in DATA_W: ArenaRAM read data, valid one cycle after the address.

## Operation
**FSM states:**
- **IDLE**
  - `vid_start` with `vid_len`≠0 latches `vid_base`/`vid_len`, clears the issue counter and enters BURST.
  - `vid_len`=0 is ignored.
- **BURST**
  - Each granted video cycle issues `addr = base + issued`, truncated to ADDR_W, so the address wraps 1023→0.
  - After issuing word `len-1`, go to DRAIN.
- **DRAIN**
  - Wait one cycle for the final read to return, pulse `vid_done`, then return to IDLE.

**Grant, evaluated combinationally each cycle:**
- Video is granted when in BURST and either `cpu_req`=0 or `wait_cnt`==MAX_WAIT.
- Otherwise the CPU is granted if `cpu_req`=1.

**Stall and wait counter:**
- `cpu_stall = cpu_req & ~cpu_grant`.
- `wait_cnt` increments each BURST cycle in which video loses.
- `wait_cnt` clears on any video grant and in IDLE/DRAIN.
- `wait_cnt` saturates at MAX_WAIT.

**RAM mux:**
- CPU grant: `ram_we=cpu_we`, `ram_addr=cpu_addr`, `ram_wdata=cpu_wdata`.
- Video grant: `ram_we=0`, `ram_addr` = burst address.
- No grant: `ram_we=0`, `ram_addr=0`.
- Video never writes.

**Return tagging:**
- A one-deep registered tag records {owner, write, idx} for the cycle just issued.
- Next cycle, `cpu_rvalid` = tag is CPU read, or `vid_valid` = tag is video, with `vid_idx` from the tag.
- `cpu_rdata` and `vid_rdata` are both driven from `ram_rdata`.
- CPU writes produce no `cpu_rvalid`.

**Boundary cases:**
- `vid_start` while `vid_busy`=1 is ignored.
- `vid_start` in the DRAIN cycle is ignored.
- Same-cycle CPU write and forced video read to the same address: video reads first (old data). The CPU write completes on its next granted cycle.
- Reset mid-burst:
  - All outputs go to 0 immediately.
  - The FSM returns to IDLE.
  - In-flight tags are discarded.
  - No `vid_done` is produced.

## Timing
- All outputs reset to 0.
- `vid_busy` is 1 from the cycle after an accepted `vid_start` until the cycle after `vid_done`.
- Latency, with no CPU traffic: first `vid_valid` 2 cycles after `vid_start`; `vid_done` at cycle `len+2`.
- Each video word is delayed by at most MAX_WAIT cycles under continuous CPU traffic.
- The CPU is stalled for at most 1 cycle per MAX_WAIT+1 while a burst is active.
- `cpu_rvalid` asserts exactly 1 cycle after an unstalled CPU read.

## Structure
- `arena_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_BURST`, `ST_DRAIN`);
  - the owner tag encoding (`OWN_NONE`, `OWN_CPU`, `OWN_VID`);
  - default ADDR_W/DATA_W/LEN_W constants.
- One sub-module, `arb_starve_counter`: a saturating counter with `inc`/`clr` inputs and a `force` output at MAX_WAIT.

## Test plan
- **Idle burst:** `vid_start`, base=0x010, len=4, `cpu_req`=0 → addresses 0x010..0x013 on consecutive cycles; `vid_valid` with idx 0..3; `vid_done` at cycle 6; no stall.
- **CPU priority/starvation:** `cpu_req`=1 every cycle, len=2, MAX_WAIT=4 → video granted on cycles 5 and 10 after BURST entry; `cpu_stall`=1 exactly on those cycles.
- **Wrap:** base=0x3FE, len=4 → `ram_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- **Hazard:** CPU write 0xDEADBEEF to 0x020 coinciding with a forced video read of 0x020 → video returns the old value; CPU is stalled 1 cycle; a subsequent CPU read returns 0xDEADBEEF.
- **Ignored starts:** `vid_len`=0 → stays IDLE. A second `vid_start` mid-burst → no effect on address sequence or length.
- **Reset mid-burst:** `reset` asserted after 2 of 8 words → all outputs 0 asynchronously; no `vid_done`; a new burst after reset starts at its own base with idx 0.
